// File: rtl/simple_axi_slave_mem.sv
// simple_axi_slave_mem: single-outstanding AXI4 responder over a 64-bit-wide
// internal memory. Single-beat INCR transfers within the decoded window get
// OKAY; bursts, unsupported sizes/bursts and misaligned addresses get SLVERR;
// addresses outside [BASE_ADDR, BASE_ADDR+MEM_BYTES) get DECERR.
// Optional macro SIMPLE_AXI_SLAVE_STALL_EN inserts STALL_CYCLES wait cycles
// (state S_STALL) before each write response and each read response.
`timescale 1ns/1ps
module simple_axi_slave_mem #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int          MEM_BYTES    = 4096,
   parameter int          STALL_CYCLES = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_awaddr,
   input  logic [2:0]  s_axi_awsize,
   input  logic [7:0]  s_axi_awlen,
   input  logic [1:0]  s_axi_awburst,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   input  logic [63:0] s_axi_wdata,
   input  logic [7:0]  s_axi_wstrb,
   input  logic        s_axi_wlast,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   output logic [1:0]  s_axi_bresp,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   input  logic [31:0] s_axi_araddr,
   input  logic [2:0]  s_axi_arsize,
   input  logic [7:0]  s_axi_arlen,
   input  logic [1:0]  s_axi_arburst,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic [63:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rlast
);

   localparam int WORDS = MEM_BYTES / 8;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Elaboration-time sanity checks on the configuration
   if (MEM_BYTES < 8 || (MEM_BYTES & (MEM_BYTES - 1)) != 0) begin : g_bad_mem_bytes
      $error("MEM_BYTES must be a power of two and at least 8");
   end
   if (STALL_CYCLES < 0) begin : g_bad_stall_cycles
      $error("STALL_CYCLES must not be negative");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_W_DATA,
      S_W_RESP,
      S_R_DATA
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
      , S_STALL
`endif
   } state_t;

   state_t           state;
   logic [63:0]      mem [0:(1 << IDX_W) - 1];
   logic [IDX_W-1:0] wr_idx;
   logic [1:0]       wr_resp;
   logic [7:0]       wr_len;
   logic [7:0]       r_cnt;
   logic [1:0]       aw_resp;
   logic [1:0]       ar_resp;
   logic             aw_fire;
   logic             ar_fire;
   logic             w_fire;
   logic             b_fire;
   logic             r_fire;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
   logic [31:0]      stall_cnt;
   logic             stall_rd;
`endif

   // Response class of an address phase: decode error, then protocol checks
   function automatic logic [1:0] classify(input logic [31:0] addr, input logic [2:0] size,
                                           input logic [7:0] len, input logic [1:0] burst);
      logic [32:0] a;
      logic [32:0] lo;
      logic [32:0] hi;
      logic        misal;
      a  = {1'b0, addr};
      lo = {1'b0, BASE_ADDR};
      hi = lo + 33'(MEM_BYTES);
      case (size)
         3'd0:    misal = 1'b0;
         3'd1:    misal = addr[0];
         3'd2:    misal = |addr[1:0];
         3'd3:    misal = |addr[2:0];
         default: misal = 1'b1;
      endcase
      if (a < lo || a >= hi)
         return RESP_DECERR;
      else if (size > 3'd3 || len != 8'd0 || burst != 2'b01 || misal)
         return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

   // 64-bit word index of a byte address relative to the window base
   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE_ADDR;
      return IDX_W'(off >> 3);
   endfunction

   // Readies are decoded from state and dropped immediately while in reset
   assign s_axi_awready = (state == S_IDLE) && !i_rst;
   assign s_axi_arready = (state == S_IDLE) && !i_rst && !s_axi_awvalid;
   assign s_axi_wready  = (state == S_W_DATA) && !i_rst;

   assign aw_fire = s_axi_awvalid && s_axi_awready;
   assign ar_fire = s_axi_arvalid && s_axi_arready;
   assign w_fire  = s_axi_wvalid && s_axi_wready;
   assign b_fire  = s_axi_bvalid && s_axi_bready;
   assign r_fire  = s_axi_rvalid && s_axi_rready;
   assign aw_resp = classify(s_axi_awaddr, s_axi_awsize, s_axi_awlen, s_axi_awburst);
   assign ar_resp = classify(s_axi_araddr, s_axi_arsize, s_axi_arlen, s_axi_arburst);

   // Memory write: commit the final beat's enabled byte lanes on an OKAY transfer
   always_ff @(posedge i_clk) begin
      if (w_fire && s_axi_wlast && wr_resp == RESP_OKAY) begin
         for (int k = 0; k < 8; k++) begin
            if (s_axi_wstrb[k])
               mem[wr_idx][8*k +: 8] <= s_axi_wdata[8*k +: 8];
         end
      end
   end

   // Transaction FSM with registered response-channel outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= S_IDLE;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
         s_axi_rvalid <= 1'b0;
         s_axi_rresp  <= RESP_OKAY;
         s_axi_rlast  <= 1'b0;
         s_axi_rdata  <= 64'd0;
         wr_idx       <= '0;
         wr_resp      <= RESP_OKAY;
         wr_len       <= 8'd0;
         r_cnt        <= 8'd0;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
         stall_cnt    <= 32'd0;
         stall_rd     <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (aw_fire) begin
                  wr_idx  <= word_idx(s_axi_awaddr);
                  wr_resp <= aw_resp;
                  wr_len  <= s_axi_awlen;
                  state   <= S_W_DATA;
               end else if (ar_fire) begin
                  s_axi_rresp <= ar_resp;
                  s_axi_rdata <= (ar_resp == RESP_OKAY) ? mem[word_idx(s_axi_araddr)] : 64'd0;
                  s_axi_rlast <= (s_axi_arlen == 8'd0);
                  r_cnt       <= s_axi_arlen;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
                  if (STALL_CYCLES == 0) begin
                     s_axi_rvalid <= 1'b1;
                     state        <= S_R_DATA;
                  end else begin
                     stall_cnt <= 32'(STALL_CYCLES - 1);
                     stall_rd  <= 1'b1;
                     state     <= S_STALL;
                  end
`else
                  s_axi_rvalid <= 1'b1;
                  state        <= S_R_DATA;
`endif
               end
            end
            S_W_DATA: begin
               if (w_fire) begin
                  if (s_axi_wlast) begin
                     s_axi_bresp <= wr_resp;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
                     if (STALL_CYCLES == 0) begin
                        s_axi_bvalid <= 1'b1;
                        state        <= S_W_RESP;
                     end else begin
                        stall_cnt <= 32'(STALL_CYCLES - 1);
                        stall_rd  <= 1'b0;
                        state     <= S_STALL;
                     end
`else
                     s_axi_bvalid <= 1'b1;
                     state        <= S_W_RESP;
`endif
                  end else if (wr_len == 8'd0) begin
                     // Initiator sent more beats than it announced
                     wr_resp <= RESP_SLVERR;
                  end
               end
            end
            S_W_RESP: begin
               if (b_fire) begin
                  s_axi_bvalid <= 1'b0;
                  s_axi_bresp  <= RESP_OKAY;
                  state        <= S_IDLE;
               end
            end
            S_R_DATA: begin
               if (r_fire) begin
                  if (r_cnt == 8'd0) begin
                     s_axi_rvalid <= 1'b0;
                     s_axi_rlast  <= 1'b0;
                     s_axi_rresp  <= RESP_OKAY;
                     s_axi_rdata  <= 64'd0;
                     state        <= S_IDLE;
                  end else begin
                     r_cnt       <= r_cnt - 8'd1;
                     s_axi_rlast <= (r_cnt == 8'd1);
                  end
               end
            end
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
            S_STALL: begin
               if (stall_cnt == 32'd0) begin
                  if (stall_rd) begin
                     s_axi_rvalid <= 1'b1;
                     state        <= S_R_DATA;
                  end else begin
                     s_axi_bvalid <= 1'b1;
                     state        <= S_W_RESP;
                  end
               end else begin
                  stall_cnt <= stall_cnt - 32'd1;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_simple_axi_slave_mem.sv
// Testbench for simple_axi_slave_mem: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a byte-level model.
`timescale 1ns/1ps
module tb_simple_axi_slave_mem;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          MEMB = 4096;
   localparam int          TMO  = 100;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
   localparam int          EXP_LAT = 4;
`else
   localparam int          EXP_LAT = 0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        awvalid = 0, awready;
   logic [31:0] awaddr = 0;
   logic [2:0]  awsize = 0;
   logic [7:0]  awlen = 0;
   logic [1:0]  awburst = 0;
   logic        wvalid = 0, wready;
   logic [63:0] wdata = 0;
   logic [7:0]  wstrb = 0;
   logic        wlast = 0;
   logic        bvalid, bready = 0;
   logic [1:0]  bresp;
   logic        arvalid = 0, arready;
   logic [31:0] araddr = 0;
   logic [2:0]  arsize = 0;
   logic [7:0]  arlen = 0;
   logic [1:0]  arburst = 0;
   logic        rvalid, rready = 0;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;

   always #5 i_clk = ~i_clk;

   simple_axi_slave_mem #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB), .STALL_CYCLES(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
      .s_axi_awsize(awsize), .s_axi_awlen(awlen), .s_axi_awburst(awburst),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
      .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
      .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
      .s_axi_arsize(arsize), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
      .s_axi_rresp(rresp), .s_axi_rlast(rlast)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] rd_data[$];
   logic [1:0]  rd_resp[$];
   logic        rd_last[$];
   int          rd_lat;

   logic [7:0]  model [logic [31:0]];

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [7:0]  len;
      logic [1:0]  burst;
      logic [63:0] data;
      logic [7:0]  strb;
      logic [1:0]  exp_resp;
      logic [63:0] exp_data;
   } vec_t;
   vec_t tbl[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string what);
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: no handshake within %0d cycles", what, TMO);
   endtask

   // Reference response from the address-phase rules, plain arithmetic
   function automatic logic [1:0] ref_resp(input logic [31:0] addr, input logic [2:0] size,
                                           input logic [7:0] len, input logic [1:0] burst);
      longint a;
      a = longint'(addr);
      if (a < longint'(BASE) || a >= longint'(BASE) + MEMB) return 2'b11;
      if (size > 3 || len != 0 || burst != 2'b01) return 2'b10;
      if ((a % (longint'(1) << size)) != 0) return 2'b10;
      return 2'b00;
   endfunction

   function automatic void model_write(input logic [31:0] addr, input logic [63:0] data,
                                       input logic [7:0] strb);
      logic [31:0] base;
      base = addr & ~32'd7;
      for (int k = 0; k < 8; k++)
         if (strb[k]) model[base + k] = data[8*k +: 8];
   endfunction

   function automatic logic [63:0] model_word(input logic [31:0] addr);
      logic [31:0] base;
      logic [63:0] w;
      base = addr & ~32'd7;
      w = 64'd0;
      for (int k = 0; k < 8; k++)
         if (model.exists(base + k)) w[8*k +: 8] = model[base + k];
      return w;
   endfunction

   task automatic axi_write(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                            input logic [1:0] burst, input logic [63:0] data, input logic [7:0] strb,
                            output logic [1:0] resp, output int lat);
      int n;
      resp = 2'b01;
      lat  = -1;
      @(posedge i_clk); #1;
      awvalid = 1; awaddr = addr; awsize = size; awlen = len; awburst = burst;
      #1;
      n = 0;
      while (!awready && n < TMO) begin @(posedge i_clk); #2; n++; end
      if (!awready) begin timeout("aw"); awvalid = 0; return; end
      @(posedge i_clk); #1;
      awvalid = 0;
      for (int b = 0; b <= int'(len); b++) begin
         wvalid = 1; wdata = data; wstrb = strb; wlast = (b == int'(len));
         #1;
         n = 0;
         while (!wready && n < TMO) begin @(posedge i_clk); #2; n++; end
         if (!wready) begin timeout("w"); wvalid = 0; wlast = 0; return; end
         @(posedge i_clk); #1;
      end
      wvalid = 0; wlast = 0;
      lat = 0;
      while (!bvalid && lat < TMO) begin @(posedge i_clk); #1; lat++; end
      if (!bvalid) begin timeout("b"); return; end
      resp = bresp;
      bready = 1;
      @(posedge i_clk); #1;
      bready = 0;
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                           input logic [1:0] burst);
      int n;
      int w;
      logic last;
      rd_data.delete(); rd_resp.delete(); rd_last.delete();
      rd_lat = -1;
      @(posedge i_clk); #1;
      arvalid = 1; araddr = addr; arsize = size; arlen = len; arburst = burst;
      #1;
      n = 0;
      while (!arready && n < TMO) begin @(posedge i_clk); #2; n++; end
      if (!arready) begin timeout("ar"); arvalid = 0; return; end
      @(posedge i_clk); #1;
      arvalid = 0;
      rd_lat = 0;
      while (!rvalid && rd_lat < TMO) begin @(posedge i_clk); #1; rd_lat++; end
      if (!rvalid) begin timeout("r"); return; end
      rready = 1;
      for (n = 0; n < 300; n++) begin
         w = 0;
         while (!rvalid && w < TMO) begin @(posedge i_clk); #1; w++; end
         if (!rvalid) begin timeout("r_beat"); break; end
         rd_data.push_back(rdata); rd_resp.push_back(rresp); rd_last.push_back(rlast);
         last = rlast;
         @(posedge i_clk); #1;
         if (last) break;
      end
      rready = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  resp;
      int          lat;
      int          n;
      int          nlast;

      // ---------- reset state ----------
      #2;
      check("rst_awready", awready, 0);
      check("rst_arready", arready, 0);
      check("rst_wready", wready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_rlast", rlast, 0);
      check("rst_resp", {bresp, rresp}, 0);
      repeat (3) @(posedge i_clk);
      @(negedge i_clk); i_rst = 0;
      @(posedge i_clk); #1;
      check("post_rst_awready", awready, 1);
      check("post_rst_arready", arready, 1);

      // ---------- directed vector table ----------
      tbl.push_back('{1, 32'h0000, 3'd3, 8'd0, 2'b01, 64'h1122_3344_5566_7788, 8'hFF, 2'b00, 64'h0});
      tbl.push_back('{1, 32'h0010, 3'd3, 8'd0, 2'b01, 64'h0, 8'hFF, 2'b00, 64'h0});
      tbl.push_back('{1, 32'h0010, 3'd2, 8'd0, 2'b01, 64'h0000_0000_DEAD_BEEF, 8'h0F, 2'b00, 64'h0});
      tbl.push_back('{0, 32'h0010, 3'd3, 8'd0, 2'b01, 64'h0, 8'h00, 2'b00, 64'h0000_0000_DEAD_BEEF});
      tbl.push_back('{1, 32'h0013, 3'd0, 8'd0, 2'b01, 64'h0000_0000_AB00_0000, 8'h08, 2'b00, 64'h0});
      tbl.push_back('{0, 32'h0010, 3'd3, 8'd0, 2'b01, 64'h0, 8'h00, 2'b00, 64'h0000_0000_ABAD_BEEF});
      tbl.push_back('{1, 32'h1000, 3'd3, 8'd0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b11, 64'h0});
      tbl.push_back('{0, 32'h1000, 3'd3, 8'd0, 2'b01, 64'h0, 8'h00, 2'b11, 64'h0});
      tbl.push_back('{1, 32'h0002, 3'd2, 8'd0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b10, 64'h0});
      tbl.push_back('{0, 32'h0000, 3'd3, 8'd0, 2'b01, 64'h0, 8'h00, 2'b00, 64'h1122_3344_5566_7788});
      tbl.push_back('{0, 32'h0010, 3'd3, 8'd0, 2'b01, 64'h0, 8'h00, 2'b00, 64'h0000_0000_ABAD_BEEF});
      tbl.push_back('{1, 32'h0020, 3'd3, 8'd0, 2'b01, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 2'b00, 64'h0});
      tbl.push_back('{1, 32'h0020, 3'd4, 8'd0, 2'b01, 64'h0, 8'hFF, 2'b10, 64'h0});
      tbl.push_back('{1, 32'h0020, 3'd3, 8'd0, 2'b00, 64'h0, 8'hFF, 2'b10, 64'h0});
      tbl.push_back('{1, 32'h0020, 3'd3, 8'd1, 2'b01, 64'h0, 8'hFF, 2'b10, 64'h0});
      tbl.push_back('{0, 32'h0020, 3'd3, 8'd0, 2'b01, 64'h0, 8'h00, 2'b00, 64'hA5A5_A5A5_A5A5_A5A5});
      tbl.push_back('{0, 32'h0020, 3'd4, 8'd0, 2'b01, 64'h0, 8'h00, 2'b10, 64'h0});
      tbl.push_back('{0, 32'h0020, 3'd3, 8'd0, 2'b10, 64'h0, 8'h00, 2'b10, 64'h0});
      tbl.push_back('{1, 32'h0FF8, 3'd3, 8'd0, 2'b01, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b00, 64'h0});
      tbl.push_back('{1, 32'h0FFF, 3'd0, 8'd0, 2'b01, 64'hEE00_0000_0000_0000, 8'h80, 2'b00, 64'h0});
      tbl.push_back('{0, 32'h0FF8, 3'd3, 8'd0, 2'b01, 64'h0, 8'h00, 2'b00, 64'hEE23_4567_89AB_CDEF});
      tbl.push_back('{0, 32'hFFFF_FFF8, 3'd3, 8'd0, 2'b01, 64'h0, 8'h00, 2'b11, 64'h0});
      tbl.push_back('{0, 32'h0001, 3'd0, 8'd0, 2'b01, 64'h0, 8'h00, 2'b00, 64'h1122_3344_5566_7788});

      foreach (tbl[i]) begin
         if (tbl[i].is_wr) begin
            axi_write(tbl[i].addr, tbl[i].size, tbl[i].len, tbl[i].burst, tbl[i].data, tbl[i].strb, resp, lat);
            check($sformatf("vec%0d_bresp", i), resp, tbl[i].exp_resp);
            check($sformatf("vec%0d_blat", i), lat, EXP_LAT);
         end else begin
            axi_read(tbl[i].addr, tbl[i].size, tbl[i].len, tbl[i].burst);
            check($sformatf("vec%0d_beats", i), rd_data.size(), 1);
            check($sformatf("vec%0d_rlat", i), rd_lat, EXP_LAT);
            if (rd_data.size() == 1) begin
               check($sformatf("vec%0d_rresp", i), rd_resp[0], tbl[i].exp_resp);
               check($sformatf("vec%0d_rdata", i), rd_data[0], tbl[i].exp_data);
               check($sformatf("vec%0d_rlast", i), rd_last[0], 1);
            end
         end
      end

      // ---------- simultaneous AW and AR: write wins ----------
      @(posedge i_clk); #1;
      awvalid = 1; awaddr = 32'h30; awsize = 3; awlen = 0; awburst = 1;
      arvalid = 1; araddr = 32'h0; arsize = 3; arlen = 0; arburst = 1;
      #1;
      check("both_awready", awready, 1);
      check("both_arready_blocked", arready, 0);
      @(posedge i_clk); #1;
      awvalid = 0;
      wvalid = 1; wdata = 64'h5555_6666_7777_8888; wstrb = 8'hFF; wlast = 1;
      #1;
      check("wdata_arready_blocked", arready, 0);
      @(posedge i_clk); #1;
      wvalid = 0; wlast = 0;
      n = 0;
      while (!bvalid && n < TMO) begin @(posedge i_clk); #1; n++; end
      check("both_bvalid", bvalid, 1);
      check("bresp_arready_blocked", arready, 0);
      bready = 1;
      @(posedge i_clk); #1;
      bready = 0;
      #1;
      check("arready_after_b", arready, 1);
      @(posedge i_clk); #1;
      arvalid = 0;
      n = 0;
      while (!rvalid && n < TMO) begin @(posedge i_clk); #1; n++; end
      check("pending_ar_rvalid", rvalid, 1);
      check("pending_ar_rdata", rdata, 64'h1122_3344_5566_7788);
      rready = 1;
      @(posedge i_clk); #1;
      rready = 0;
      axi_read(32'h30, 3, 0, 1);
      check("both_wr_readback", rd_data.size() > 0 ? rd_data[0] : 64'hX, 64'h5555_6666_7777_8888);

      // ---------- burst read len 3 with back-pressure on beat 2 ----------
      @(posedge i_clk); #1;
      arvalid = 1; araddr = 32'h0; arsize = 3; arlen = 3; arburst = 1;
      #1;
      n = 0;
      while (!arready && n < TMO) begin @(posedge i_clk); #2; n++; end
      @(posedge i_clk); #1;
      arvalid = 0;
      for (int b = 0; b < 4; b++) begin
         n = 0;
         while (!rvalid && n < TMO) begin @(posedge i_clk); #1; n++; end
         check($sformatf("burst_b%0d_rvalid", b), rvalid, 1);
         check($sformatf("burst_b%0d_rresp", b), rresp, 2'b10);
         check($sformatf("burst_b%0d_rdata", b), rdata, 0);
         check($sformatf("burst_b%0d_rlast", b), rlast, (b == 3));
         if (b == 1) begin
            for (int h = 0; h < 5; h++) begin
               @(posedge i_clk); #1;
               check($sformatf("hold%0d", h), {rvalid, rlast, rresp, rdata}, {1'b1, 1'b0, 2'b10, 64'h0});
            end
         end
         rready = 1;
         @(posedge i_clk); #1;
         rready = 0;
      end
      check("burst_done_rvalid", rvalid, 0);

      // ---------- len 255 burst: counter must not overflow ----------
      axi_read(32'h0, 3, 8'd255, 1);
      check("len255_beats", rd_data.size(), 256);
      nlast = 0;
      foreach (rd_last[i]) nlast += int'(rd_last[i]);
      check("len255_nlast", nlast, 1);
      check("len255_final_last", rd_last.size() == 256 ? rd_last[255] : 1'bx, 1);

      // ---------- reset during S_W_DATA ----------
      axi_write(32'h40, 3, 0, 1, 64'h0BAD_F00D_CAFE_1234, 8'hFF, resp, lat);
      check("pre_rst_bresp", resp, 0);
      @(posedge i_clk); #1;
      awvalid = 1; awaddr = 32'h40; awsize = 3; awlen = 0; awburst = 1;
      @(posedge i_clk); #1;
      awvalid = 0;
      wvalid = 1; wdata = 64'hFFFF_FFFF_FFFF_FFFF; wstrb = 8'hFF; wlast = 1;
      #1;
      check("wready_before_rst", wready, 1);
      #1 i_rst = 1;
      #1;
      check("rst_mid_wready", wready, 0);
      check("rst_mid_bvalid", bvalid, 0);
      @(posedge i_clk); #1;
      wvalid = 0; wlast = 0;
      @(negedge i_clk); i_rst = 0;
      @(posedge i_clk); #1;
      check("rst_mid_idle_awready", awready, 1);
      axi_read(32'h40, 3, 0, 1);
      check("rst_mid_no_write", rd_data.size() > 0 ? rd_data[0] : 64'hX, 64'h0BAD_F00D_CAFE_1234);

      // ---------- randomized traffic against the byte model ----------
      for (int w = 0; w < 8; w++) begin
         logic [63:0] d;
         d = {$urandom, $urandom};
         axi_write(32'h100 + 32'(w * 8), 3, 0, 1, d, 8'hFF, resp, lat);
         model_write(32'h100 + 32'(w * 8), d, 8'hFF);
      end
      for (int t = 0; t < 150; t++) begin
         logic [31:0] a;
         logic [2:0]  sz;
         logic [7:0]  ln;
         logic [1:0]  bu;
         logic [63:0] d;
         logic [7:0]  st;
         logic [1:0]  er;
         a  = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 32'hFFFF_EFFF)
                                           : 32'h100 + 32'($urandom_range(0, 63));
         sz = ($urandom_range(0, 9) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << (sz > 3 ? 3 : sz)) - 1);
         ln = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
         bu = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
         d  = {$urandom, $urandom};
         st = 8'($urandom);
         er = ref_resp(a, sz, ln, bu);
         if ($urandom_range(0, 1) == 0) begin
            axi_write(a, sz, ln, bu, d, st, resp, lat);
            check($sformatf("rnd%0d_bresp", t), resp, er);
            if (er == 2'b00) model_write(a, d, st);
         end else begin
            axi_read(a, sz, ln, bu);
            check($sformatf("rnd%0d_beats", t), rd_data.size(), int'(ln) + 1);
            foreach (rd_data[i]) begin
               check($sformatf("rnd%0d_b%0d_rresp", t, i), rd_resp[i], er);
               check($sformatf("rnd%0d_b%0d_rdata", t, i), rd_data[i], (er == 2'b00) ? model_word(a) : 64'd0);
               check($sformatf("rnd%0d_b%0d_rlast", t, i), rd_last[i], (i == int'(ln)));
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
